audio_tone_ctrl: RTL and testbench

Sine-tone sequencer for the audio path. It owns a 256-entry signed sine LUT and steps through it with a phase accumulator, one entry per sample request from the I2S transmitter. It applies per-sample attenuation and ends every tone on a phase wrap, so tones always stop at a zero crossing with no click. Control registers or buttons drive start, stop, frequency and duration.

---
 rtl/audio_pkg.sv | 56 +++++
 rtl/sine_lut.sv | 27 ++
 rtl/audio_tone_ctrl.sv | 157 +++++++++++++++
 tb/tb_audio_tone_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared definitions for the audio tone path.
//   SINE_DEPTH / SINE_AW : sine table depth and address width
//   AUDIO_DW             : sample width (signed two's complement)
//   tone_state_t         : tone sequencer state (IDLE / RUN / DRAIN)
//   sine_entry(k)        : round(32767 * sin(2*pi*k/256)), evaluated at
//                          elaboration time to build the sine ROM
package audio_pkg;

  localparam int SINE_DEPTH = 256;
  localparam int SINE_AW    = 8;
  localparam int AUDIO_DW   = 16;

  // pi in Q30 fixed point (0xC90FDAA2)
  localparam longint PI_Q30 = 64'sd3373259426;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } tone_state_t;

  // First-quadrant magnitude for n = 0..64, i.e. round(32767*sin(n*pi/128)).
  // Integer Taylor series in Q30; the truncation error is far below the
  // rounding margin of every entry, so the table comes out exact.
  function automatic logic signed [AUDIO_DW-1:0] sine_quarter(input int n);
    longint x;
    longint term;
    longint acc;
    x    = (longint'(n) * PI_Q30) >>> 7;
    term = x;
    acc  = x;
    for (int i = 1; i <= 7; i++) begin
      term = (term * x) >>> 30;
      term = (term * x) >>> 30;
      term = term / longint'((2 * i) * (2 * i + 1));
      if ((i % 2) == 1) acc = acc - term;
      else              acc = acc + term;
    end
    return AUDIO_DW'((acc * 64'sd32767 + (64'sd1 <<< 29)) >>> 30);
  endfunction

  // Full-wave entry built from the quarter wave by symmetry.
  function automatic logic signed [AUDIO_DW-1:0] sine_entry(input int k);
    int idx;
    logic signed [AUDIO_DW-1:0] val;
    idx = k % 64;
    case ((k / 64) % 4)
      0:       val = sine_quarter(idx);
      1:       val = sine_quarter(64 - idx);
      2:       val = -sine_quarter(idx);
      default: val = -sine_quarter(64 - idx);
    endcase
    return val;
  endfunction

endpackage

// File: rtl/sine_lut.sv
// sine_lut: 256 x 16 signed sine ROM with a synchronous, one-cycle read.
//   clk   : clock
//   rst_n : synchronous active-low reset, clears the read register
//   addr  : table address
//   data  : registered table entry for the address of the previous cycle
module sine_lut
  import audio_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [SINE_AW-1:0]         addr,
  output logic signed [AUDIO_DW-1:0] data
);

  logic signed [AUDIO_DW-1:0] rom [SINE_DEPTH];

  for (genvar gi = 0; gi < SINE_DEPTH; gi++) begin : g_rom
    localparam logic signed [AUDIO_DW-1:0] ENTRY = sine_entry(gi);
    assign rom[gi] = ENTRY;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) data <= '0;
    else        data <= rom[addr];
  end

endmodule

// File: rtl/audio_tone_ctrl.sv
// audio_tone_ctrl: sine-tone sequencer feeding the I2S transmitter.
//   clk, rst_n   : clock, synchronous active-low reset
//   start, stop  : tone control pulses (start wins when both are high)
//   phase_inc    : phase step per sample, latched on start
//   duration     : tone length in samples (0 = continuous), latched on start
//   atten        : arithmetic right shift applied to each sample
//   sample_req   : one pulse per audio frame
//   sample_out   : attenuated sample, held between valids
//   sample_valid : one pulse per sample_req, three edges after it
//   busy         : tone playing or draining
//   done         : pulses with the last sample of a tone
// Tones always end on a phase wrap so the output stops at a zero crossing.
module audio_tone_ctrl
  import audio_pkg::*;
#(
  parameter int PHASE_W = 24,
  parameter int DATA_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic [PHASE_W-1:0]       phase_inc,
  input  logic [15:0]              duration,
  input  logic [3:0]               atten,
  input  logic                     sample_req,
  output logic signed [DATA_W-1:0] sample_out,
  output logic                     sample_valid,
  output logic                     busy,
  output logic                     done
);

  tone_state_t        state_reg, state_next;
  logic [PHASE_W-1:0] phase_reg, phase_next;
  logic [PHASE_W-1:0] inc_reg, inc_next;
  logic [15:0]        dur_reg, dur_next;
  logic [15:0]        rem_reg, rem_next;

  // Values as seen this cycle once a coincident start has been applied, so
  // a sample_req in the start cycle already plays the new tone from phase 0.
  tone_state_t        eff_state;
  logic [PHASE_W-1:0] eff_phase, eff_inc;
  logic [15:0]        eff_dur, eff_rem;
  logic               stop_eff;

  logic               carry;
  logic [PHASE_W-1:0] phase_sum;
  logic [15:0]        rem_dec;
  logic               accept;
  logic               end_tone;
  logic [SINE_AW-1:0] req_addr;

  // sample pipeline
  logic                       v1_reg, v2_reg, valid_reg;
  logic                       done1_reg, done2_reg, done_reg;
  logic [SINE_AW-1:0]         addr1_reg;
  logic [3:0]                 atten1_reg, atten2_reg;
  logic signed [AUDIO_DW-1:0] lut_data;
  logic signed [DATA_W-1:0]   out_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      phase_reg <= '0;
      inc_reg   <= '0;
      dur_reg   <= '0;
      rem_reg   <= '0;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      inc_reg   <= inc_next;
      dur_reg   <= dur_next;
      rem_reg   <= rem_next;
    end
  end

  always_comb begin
    eff_state = start ? RUN : state_reg;
    eff_phase = start ? '0 : phase_reg;
    eff_inc   = start ? phase_inc : inc_reg;
    eff_dur   = start ? duration : dur_reg;
    eff_rem   = start ? duration : rem_reg;
    stop_eff  = stop & ~start;

    {carry, phase_sum} = {1'b0, eff_phase} + {1'b0, eff_inc};
    rem_dec  = (eff_rem == 16'd0) ? 16'd0 : eff_rem - 16'd1;
    accept   = sample_req && (eff_state != IDLE);
    // A zero step never wraps, so a draining tone with phase_inc 0 would
    // otherwise never finish; it ends on its next sample instead.
    end_tone = accept &&
               ((carry && ((eff_state == DRAIN) || stop_eff ||
                           ((eff_rem == 16'd1) && (eff_dur != 16'd0)))) ||
                ((eff_state == DRAIN) && (eff_inc == '0)));
    req_addr = eff_phase[PHASE_W-1 -: SINE_AW];

    state_next = eff_state;
    phase_next = eff_phase;
    inc_next   = eff_inc;
    dur_next   = eff_dur;
    rem_next   = eff_rem;

    if (end_tone) begin
      state_next = IDLE;
      phase_next = '0;
      rem_next   = rem_dec;
    end else if (accept) begin
      phase_next = phase_sum;
      rem_next   = rem_dec;
      if (stop_eff || ((eff_dur != 16'd0) && (rem_dec == 16'd0)))
        state_next = DRAIN;
    end else if ((eff_state == RUN) && stop_eff) begin
      state_next = DRAIN;
    end
  end

  // In IDLE the phase is held at 0, so idle requests read entry 0 (= 0).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_reg     <= 1'b0;
      done1_reg  <= 1'b0;
      addr1_reg  <= '0;
      atten1_reg <= '0;
      v2_reg     <= 1'b0;
      done2_reg  <= 1'b0;
      atten2_reg <= '0;
      valid_reg  <= 1'b0;
      done_reg   <= 1'b0;
      out_reg    <= '0;
    end else begin
      v1_reg     <= sample_req;
      done1_reg  <= end_tone;
      if (sample_req) begin
        addr1_reg  <= req_addr;
        atten1_reg <= atten;
      end
      v2_reg     <= v1_reg;
      done2_reg  <= done1_reg;
      atten2_reg <= atten1_reg;
      valid_reg  <= v2_reg;
      done_reg   <= done2_reg;
      if (v2_reg) out_reg <= lut_data >>> atten2_reg;
    end
  end

  sine_lut u_sine_lut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (addr1_reg),
    .data  (lut_data)
  );

  assign sample_out   = out_reg;
  assign sample_valid = valid_reg;
  assign done         = done_reg;
  assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_audio_tone_ctrl.sv
// tb_audio_tone_ctrl: directed self-checking bench for audio_tone_ctrl.
// Expected samples come from a floating-point sine model and hand values.
module tb_audio_tone_ctrl;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic [23:0]        phase_inc = '0;
  logic [15:0]        duration = '0;
  logic [3:0]         atten = '0;
  logic               sample_req = 1'b0;
  logic signed [15:0] sample_out;
  logic               sample_valid;
  logic               busy;
  logic               done;

  int tests_run = 0;
  int fails = 0;

  always #5 clk = ~clk;

  audio_tone_ctrl #(.PHASE_W(24), .DATA_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .phase_inc    (phase_inc),
    .duration     (duration),
    .atten        (atten),
    .sample_req   (sample_req),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .busy         (busy),
    .done         (done)
  );

  function automatic int exp_sine(input int k);
    real r;
    r = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(k) / 256.0);
    if (r >= 0.0) return $rtoi($floor(r + 0.5));
    else          return -$rtoi($floor(-r + 0.5));
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [23:0] inc, input logic [15:0] dur);
    phase_inc = inc;
    duration  = dur;
    start     = 1'b1;
    cyc();
    start     = 1'b0;
    phase_inc = 24'h5A5A5A;
    duration  = 16'd3;
    $display("[TB] start phase_inc=%h duration=%0d", inc, dur);
  endtask

  // One sample request; returns what appears three edges later and whether
  // any valid showed up too early. atten is scrambled after the request edge.
  task automatic get_sample(input logic [3:0] a, input logic with_start,
                            input logic with_stop, output logic signed [15:0] s,
                            output logic v, output logic d, output logic early);
    sample_req = 1'b1;
    atten      = a;
    start      = with_start;
    stop       = with_stop;
    cyc();
    early      = sample_valid;
    sample_req = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    atten      = ~a;
    cyc();
    early      = early | sample_valid;
    cyc();
    v = sample_valid;
    s = sample_out;
    d = done;
    $display("[TB] req atten=%0d -> valid=%0b out=%0d done=%0b busy=%0b", a, v, s, d, busy);
  endtask

  task automatic test_reset();
    logic signed [15:0] s;
    logic v, d, early;
    rst_n = 1'b0;
    sample_req = 1'b1;
    cyc();
    cyc();
    sample_req = 1'b0;
    tests_run++;
    if ({sample_valid, busy, done} !== 3'b000 || sample_out !== 16'sd0) begin
      fails++;
      $display("FAIL reset_state valid=%0b busy=%0b done=%0b out=%0d required 0 0 0 0",
               sample_valid, busy, done, sample_out);
    end
    rst_n = 1'b1;
    cyc();
    for (int i = 0; i < 4; i++) begin
      get_sample(4'd0, 1'b0, 1'b0, s, v, d, early);
      tests_run++;
      if ({v, d, early, busy} !== 4'b1000 || s !== 16'sd0) begin
        fails++;
        $display("FAIL idle_req[%0d] valid=%0b done=%0b early=%0b busy=%0b out=%0d required valid=1 done=0 early=0 busy=0 out=0",
                 i, v, d, early, busy, s);
      end
      repeat (5) cyc();
    end
  endtask

  task automatic test_continuous();
    logic signed [15:0] s, e;
    logic v, d, early;
    logic signed [15:0] seen [256];
    do_start(24'h010000, 16'd0);
    for (int n = 0; n < 258; n++) begin
      get_sample(4'd0, 1'b0, 1'b0, s, v, d, early);
      e = 16'(exp_sine(n % 256));
      if (n < 256) seen[n] = s;
      tests_run++;
      if ({v, d, early, busy} !== 4'b1001 || s !== e) begin
        fails++;
        $display("FAIL cont[%0d] valid=%0b done=%0b early=%0b busy=%0b out=%0d required valid=1 done=0 early=0 busy=1 out=%0d",
                 n, v, d, early, busy, s, e);
      end
    end
    tests_run++;
    if (seen[1] !== 16'sd804 || seen[3] !== 16'sd2410 || seen[64] !== 16'sd32767 ||
        seen[128] !== 16'sd0 || seen[192] !== -16'sd32767) begin
      fails++;
      $display("FAIL cont_hand got %0d %0d %0d %0d %0d required 804 2410 32767 0 -32767",
               seen[1], seen[3], seen[64], seen[128], seen[192]);
    end
  endtask

  task automatic test_atten();
    logic signed [15:0] s, e;
    logic v, d, early;
    logic [3:0] a;
    logic signed [15:0] seen [256];
    do_start(24'h010000, 16'd0);
    for (int n = 0; n <= 192; n++) begin
      get_sample(4'd15, 1'b0, 1'b0, s, v, d, early);
      seen[n] = s;
      e = 16'(exp_sine(n) >>> 15);
      tests_run++;
      if ({v, early} !== 2'b10 || s !== e) begin
        fails++;
        $display("FAIL atten15[%0d] valid=%0b early=%0b out=%0d required valid=1 early=0 out=%0d",
                 n, v, early, s, e);
      end
    end
    tests_run++;
    if (seen[64] !== 16'sd0 || seen[192] !== -16'sd1) begin
      fails++;
      $display("FAIL atten15_hand got %0d %0d required 0 -1", seen[64], seen[192]);
    end
    do_start(24'h010000, 16'd0);
    for (int n = 0; n <= 64; n++) begin
      a = (n < 60) ? 4'd15 : 4'd1;
      get_sample(a, 1'b0, 1'b0, s, v, d, early);
      e = 16'(exp_sine(n) >>> a);
      tests_run++;
      if (v !== 1'b1 || s !== e) begin
        fails++;
        $display("FAIL atten_change[%0d] valid=%0b out=%0d required valid=1 out=%0d", n, v, s, e);
      end
      if (n == 64) begin
        tests_run++;
        if (s !== 16'sd16383) begin
          fails++;
          $display("FAIL atten1_peak out=%0d required 16383", s);
        end
      end
    end
  endtask

  task automatic test_duration();
    logic signed [15:0] s;
    logic v, d, early;
    logic signed [15:0] exp_v [4];
    exp_v[0] = 16'sd0;
    exp_v[1] = 16'sd32767;
    exp_v[2] = 16'sd0;
    exp_v[3] = -16'sd32767;
    do_start(24'h400000, 16'd4);
    for (int n = 0; n < 4; n++) begin
      get_sample(4'd0, 1'b0, 1'b0, s, v, d, early);
      tests_run++;
      if (v !== 1'b1 || d !== (n == 3) || s !== exp_v[n] || busy !== (n != 3)) begin
        fails++;
        $display("FAIL dur4[%0d] valid=%0b done=%0b busy=%0b out=%0d required valid=1 done=%0b busy=%0b out=%0d",
                 n, v, d, busy, s, (n == 3), (n != 3), exp_v[n]);
      end
    end
    get_sample(4'd0, 1'b0, 1'b0, s, v, d, early);
    tests_run++;
    if ({v, d, busy} !== 3'b100 || s !== 16'sd0) begin
      fails++;
      $display("FAIL dur4_after valid=%0b done=%0b busy=%0b out=%0d required 1 0 0 0", v, d, busy, s);
    end
  endtask

  task automatic test_stop();
    logic signed [15:0] s, e;
    logic v, d, early;
    do_start(24'h010000, 16'd0);
    for (int n = 0; n < 10; n++) get_sample(4'd0, 1'b0, 1'b0, s, v, d, early);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL stop_busy busy=%0b required 1", busy);
    end
    for (int n = 10; n < 256; n++) begin
      get_sample(4'd0, 1'b0, 1'b0, s, v, d, early);
      e = 16'(exp_sine(n));
      tests_run++;
      if (v !== 1'b1 || d !== (n == 255) || s !== e) begin
        fails++;
        $display("FAIL drain[%0d] valid=%0b done=%0b out=%0d required valid=1 done=%0b out=%0d",
                 n, v, d, s, (n == 255), e);
      end
      if (n == 255) begin
        tests_run++;
        if (s !== -16'sd804 || busy !== 1'b0) begin
          fails++;
          $display("FAIL drain_last out=%0d busy=%0b required -804 0", s, busy);
        end
      end
    end
    get_sample(4'd0, 1'b0, 1'b0, s, v, d, early);
    tests_run++;
    if ({v, d, busy} !== 3'b100 || s !== 16'sd0) begin
      fails++;
      $display("FAIL drain_after valid=%0b done=%0b busy=%0b out=%0d required 1 0 0 0", v, d, busy, s);
    end
    // zero step: the draining tone ends on the next sample
    do_start(24'h000000, 16'd0);
    get_sample(4'd0, 1'b0, 1'b0, s, v, d, early);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    get_sample(4'd0, 1'b0, 1'b0, s, v, d, early);
    tests_run++;
    if ({v, d, busy} !== 3'b110 || s !== 16'sd0) begin
      fails++;
      $display("FAIL inc0_drain valid=%0b done=%0b busy=%0b out=%0d required 1 1 0 0", v, d, busy, s);
    end
  endtask

  task automatic test_restart();
    logic signed [15:0] s, e;
    logic v, d, early;
    logic signed [15:0] exp_v [4];
    exp_v[0] = 16'sd0;
    exp_v[1] = 16'sd32767;
    exp_v[2] = 16'sd0;
    exp_v[3] = -16'sd32767;
    do_start(24'h010000, 16'd0);
    for (int n = 0; n < 100; n++) get_sample(4'd0, 1'b0, 1'b0, s, v, d, early);
    do_start(24'h010000, 16'd0);
    for (int n = 0; n < 2; n++) begin
      get_sample(4'd0, 1'b0, 1'b0, s, v, d, early);
      e = (n == 0) ? 16'sd0 : 16'sd804;
      tests_run++;
      if ({v, d, busy} !== 3'b101 || s !== e) begin
        fails++;
        $display("FAIL restart[%0d] valid=%0b done=%0b busy=%0b out=%0d required 1 0 1 %0d", n, v, d, busy, s, e);
      end
    end
    for (int n = 2; n < 50; n++) get_sample(4'd0, 1'b0, 1'b0, s, v, d, early);
    // start together with a request: the request plays address 0
    phase_inc = 24'h020000;
    duration  = 16'd0;
    for (int n = 0; n < 3; n++) begin
      get_sample(4'd0, (n == 0), 1'b0, s, v, d, early);
      phase_inc = 24'h5A5A5A;
      e = 16'(exp_sine(2 * n));
      tests_run++;
      if ({v, d, busy} !== 3'b101 || s !== e) begin
        fails++;
        $display("FAIL start_with_req[%0d] valid=%0b done=%0b busy=%0b out=%0d required 1 0 1 %0d", n, v, d, busy, s, e);
      end
    end
    // start and stop together: start wins, tone keeps running past the wrap
    phase_inc = 24'h400000;
    duration  = 16'd0;
    start = 1'b1;
    stop  = 1'b1;
    cyc();
    start = 1'b0;
    stop  = 1'b0;
    phase_inc = 24'h5A5A5A;
    for (int n = 0; n < 4; n++) begin
      get_sample(4'd0, 1'b0, 1'b0, s, v, d, early);
      tests_run++;
      if ({v, d, busy} !== 3'b101 || s !== exp_v[n]) begin
        fails++;
        $display("FAIL start_stop[%0d] valid=%0b done=%0b busy=%0b out=%0d required 1 0 1 %0d", n, v, d, busy, s, exp_v[n]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic signed [15:0] e;
    do_start(24'h010000, 16'd0);
    sample_req = 1'b1;
    atten = 4'd0;
    for (int c = 1; c <= 11; c++) begin
      cyc();
      if (c == 8) sample_req = 1'b0;
      e = (c >= 3 && c <= 10) ? 16'(exp_sine(c - 3)) : 16'sd0;
      tests_run++;
      if (sample_valid !== (c >= 3 && c <= 10) || ((c >= 3 && c <= 10) && sample_out !== e)) begin
        fails++;
        $display("FAIL b2b[%0d] valid=%0b out=%0d required valid=%0b out=%0d",
                 c, sample_valid, sample_out, (c >= 3 && c <= 10), e);
      end
    end
    $display("[TB] back-to-back burst of 8 requests done");
  endtask

  task automatic test_reset_mid();
    logic signed [15:0] s;
    logic v, d, early;
    do_start(24'h010000, 16'd0);
    for (int n = 0; n < 20; n++) get_sample(4'd0, 1'b0, 1'b0, s, v, d, early);
    sample_req = 1'b1;
    cyc();
    cyc();
    sample_req = 1'b0;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tests_run++;
      if ({sample_valid, busy, done} !== 3'b000 || sample_out !== 16'sd0) begin
        fails++;
        $display("FAIL reset_mid[%0d] valid=%0b busy=%0b done=%0b out=%0d required 0 0 0 0",
                 c, sample_valid, busy, done, sample_out);
      end
      cyc();
    end
    get_sample(4'd0, 1'b0, 1'b0, s, v, d, early);
    tests_run++;
    if ({v, d, busy} !== 3'b100 || s !== 16'sd0) begin
      fails++;
      $display("FAIL reset_mid_after valid=%0b done=%0b busy=%0b out=%0d required 1 0 0 0", v, d, busy, s);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_continuous();
    test_atten();
    test_duration();
    test_stop();
    test_restart();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
